// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: size codes, write-back
// select codes, FSM states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] WSEL_ALU  = 3'd0;
    localparam logic [2:0] WSEL_DRAM = 3'd1;
    localparam logic [2:0] WSEL_PC4  = 3'd2;
    localparam logic [2:0] WSEL_EXT  = 3'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Size code 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction plus extension for loads.
// Purely combinational.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    // Store path: replicate the narrow datum across the word and enable only its lanes.
    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    // Load path: pick the addressed lane, then sign- or zero-extend.
    always_comb begin
        lane8   = rdata[{addr_lo, 3'b000} +: 8];
        lane16  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        case (size)
            SZ_B:    ld_data = {{24{~is_unsigned & lane8[7]}}, lane8};
            SZ_H:    ld_data = {{16{~is_unsigned & lane16[15]}}, lane16};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues one data-memory bus transaction per load/store,
// stalls the front of the pipeline until ack, and owns the MEM/WB register.
//
// state | meaning
// IDLE  | no transaction outstanding; aligned memory op raises the stall and issues
// BUSY  | request registered on the bus, waiting for bus_ack
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        have_inst_MEM,
    input  logic [31:0] MEM_C,
    input  logic [31:0] MEM_rD2,
    input  logic        MEM_dram_we,
    input  logic [1:0]  MEM_op,
    input  logic        MEM_rf_we,
    input  logic [2:0]  MEM_rf_wsel,
    input  logic [31:0] MEM_pc4,
    input  logic [31:0] MEM_ext,
    input  logic [31:0] MEM_inst,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall_mem,
    output logic        WB_rf_we,
    output logic [2:0]  WB_rf_wsel,
    output logic [4:0]  WB_wR,
    output logic [31:0] WB_wD,
    output logic [31:0] WB_pc4,
    output logic [31:0] WB_ext,
    output logic [31:0] WB_inst,
    output logic        have_inst_WB,
    output logic        misalign
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic        wb_rf_we_q, wb_rf_we_d;
    logic [2:0]  wb_rf_wsel_q, wb_rf_wsel_d;
    logic [4:0]  wb_wr_q, wb_wr_d;
    logic [31:0] wb_wd_q, wb_wd_d;
    logic [31:0] wb_pc4_q, wb_pc4_d;
    logic [31:0] wb_ext_q, wb_ext_d;
    logic [31:0] wb_inst_q, wb_inst_d;
    logic        have_wb_q, have_wb_d;
    logic        misalign_q, misalign_d;

    logic        mem_op;
    logic        mis;
    logic        aligned_op;
    logic        stall;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [31:0] wd_sel;

    mem_lane_align u_lane (
        .size        (MEM_op),
        .addr_lo     (MEM_C[1:0]),
        .st_data     (MEM_rD2),
        .is_unsigned (MEM_inst[14]),
        .rdata       (bus_rdata),
        .be          (st_be),
        .wdata       (st_wdata),
        .ld_data     (ld_data)
    );

    // Classify the MEM slot and derive the combinational stall.
    // stall is forced low under reset so every output reads 0 while rst is high.
    always_comb begin
        mem_op     = have_inst_MEM & (MEM_dram_we | (MEM_rf_wsel == WSEL_DRAM));
        mis        = is_misaligned(MEM_op, MEM_C[1:0]);
        aligned_op = mem_op & ~mis;
        stall      = ~rst & (((state_q == IDLE) & aligned_op) |
                             ((state_q == BUSY) & ~bus_ack));
    end

    // Write-back data select; DRAM data is only meaningful in the ack cycle.
    always_comb begin
        wd_sel = MEM_C;
        case (MEM_rf_wsel)
            WSEL_DRAM: wd_sel = ld_data;
            WSEL_ALU:  wd_sel = MEM_C;
            WSEL_PC4:  wd_sel = MEM_pc4;
            WSEL_EXT:  wd_sel = MEM_ext;
            default:   wd_sel = MEM_C;
        endcase
    end

    // Next state and request registers; request fields are frozen for the whole BUSY period.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (aligned_op) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = MEM_dram_we;
                    addr_d  = {MEM_C[31:2], 2'b00};
                    be_d    = MEM_dram_we ? st_be : 4'b1111;
                    wdata_d = MEM_dram_we ? st_wdata : 32'h0;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'h0;
                    be_d    = 4'b0000;
                    wdata_d = 32'h0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MEM/WB register input: a bubble while stalled, otherwise the MEM slot.
    // A misaligned access still retires but must not write the register file.
    always_comb begin
        wb_rf_we_d   = 1'b0;
        wb_rf_wsel_d = 3'd0;
        wb_wr_d      = 5'd0;
        wb_wd_d      = 32'h0;
        wb_pc4_d     = 32'h0;
        wb_ext_d     = 32'h0;
        wb_inst_d    = 32'h0;
        have_wb_d    = 1'b0;
        misalign_d   = (state_q == IDLE) & mem_op & mis;
        if (!stall) begin
            wb_rf_we_d   = have_inst_MEM & MEM_rf_we & ~(mem_op & mis);
            wb_rf_wsel_d = MEM_rf_wsel;
            wb_wr_d      = MEM_inst[11:7];
            wb_wd_d      = wd_sel;
            wb_pc4_d     = MEM_pc4;
            wb_ext_d     = MEM_ext;
            wb_inst_d    = MEM_inst;
            have_wb_d    = have_inst_MEM;
        end
    end

    // State, request and MEM/WB flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0;
            wb_rf_we_q   <= 1'b0;
            wb_rf_wsel_q <= 3'd0;
            wb_wr_q      <= 5'd0;
            wb_wd_q      <= 32'h0;
            wb_pc4_q     <= 32'h0;
            wb_ext_q     <= 32'h0;
            wb_inst_q    <= 32'h0;
            have_wb_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            wb_rf_we_q   <= wb_rf_we_d;
            wb_rf_wsel_q <= wb_rf_wsel_d;
            wb_wr_q      <= wb_wr_d;
            wb_wd_q      <= wb_wd_d;
            wb_pc4_q     <= wb_pc4_d;
            wb_ext_q     <= wb_ext_d;
            wb_inst_q    <= wb_inst_d;
            have_wb_q    <= have_wb_d;
            misalign_q   <= misalign_d;
        end
    end

    assign bus_req      = req_q;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_be       = be_q;
    assign bus_wdata    = wdata_q;
    assign stall_mem    = stall;
    assign WB_rf_we     = wb_rf_we_q;
    assign WB_rf_wsel   = wb_rf_wsel_q;
    assign WB_wR        = wb_wr_q;
    assign WB_wD        = wb_wd_q;
    assign WB_pc4       = wb_pc4_q;
    assign WB_ext       = wb_ext_q;
    assign WB_inst      = wb_inst_q;
    assign have_inst_WB = have_wb_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small acking bus model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        have_inst_MEM;
    logic [31:0] MEM_C;
    logic [31:0] MEM_rD2;
    logic        MEM_dram_we;
    logic [1:0]  MEM_op;
    logic        MEM_rf_we;
    logic [2:0]  MEM_rf_wsel;
    logic [31:0] MEM_pc4;
    logic [31:0] MEM_ext;
    logic [31:0] MEM_inst;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_mem;
    logic        WB_rf_we;
    logic [2:0]  WB_rf_wsel;
    logic [4:0]  WB_wR;
    logic [31:0] WB_wD;
    logic [31:0] WB_pc4;
    logic [31:0] WB_ext;
    logic [31:0] WB_inst;
    logic        have_inst_WB;
    logic        misalign;

    int n_chk = 0;
    int n_err = 0;
    int op_stalls;
    int op_starts;
    int wb_pulses = 0;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_we;
    int wb_base;

    mem_access_unit dut (
        .clk           (clk),
        .rst           (rst),
        .have_inst_MEM (have_inst_MEM),
        .MEM_C         (MEM_C),
        .MEM_rD2       (MEM_rD2),
        .MEM_dram_we   (MEM_dram_we),
        .MEM_op        (MEM_op),
        .MEM_rf_we     (MEM_rf_we),
        .MEM_rf_wsel   (MEM_rf_wsel),
        .MEM_pc4       (MEM_pc4),
        .MEM_ext       (MEM_ext),
        .MEM_inst      (MEM_inst),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .stall_mem     (stall_mem),
        .WB_rf_we      (WB_rf_we),
        .WB_rf_wsel    (WB_rf_wsel),
        .WB_wR         (WB_wR),
        .WB_wD         (WB_wD),
        .WB_pc4        (WB_pc4),
        .WB_ext        (WB_ext),
        .WB_inst       (WB_inst),
        .have_inst_WB  (have_inst_WB),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && have_inst_WB) wb_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, 7'h03};
    endfunction

    task automatic set_op(input logic have, input logic [31:0] c, input logic [31:0] rd2,
                          input logic we, input logic [1:0] op, input logic rf_we,
                          input logic [2:0] wsel, input logic [31:0] pc4,
                          input logic [31:0] ext, input logic [31:0] inst);
        have_inst_MEM = have;
        MEM_C         = c;
        MEM_rD2       = rd2;
        MEM_dram_we   = we;
        MEM_op        = op;
        MEM_rf_we     = rf_we;
        MEM_rf_wsel   = wsel;
        MEM_pc4       = pc4;
        MEM_ext       = ext;
        MEM_inst      = inst;
    endtask

    task automatic bubble();
        set_op(1'b0, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Called just after a rising edge with the MEM fields applied; returns just
    // after the edge that retires the instruction (first cycle with stall low).
    task automatic run_op(input int ack_wait, input logic [31:0] rdata);
        int  n;
        logic prev_req;
        logic st;
        logic done;
        n = 0; prev_req = 1'b0; done = 1'b0;
        op_stalls = 0; op_starts = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            bus_ack   = bus_req && (n >= ack_wait);
            bus_rdata = bus_ack ? rdata : 32'hDEADBEEF;
            #1;
            if (bus_req && !prev_req) begin
                op_starts++;
                cap_addr  = bus_addr;
                cap_be    = bus_be;
                cap_wdata = bus_wdata;
                cap_we    = bus_we;
            end
            prev_req = bus_req;
            if (bus_req) n++;
            st = stall_mem;
            if (st) op_stalls++;
            @(posedge clk);
            #1;
            bus_ack   = 1'b0;
            bus_rdata = 32'hDEADBEEF;
            if (!st) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        bubble();
        #3;
        chk("rst_bus_req",  {31'h0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be",   {28'h0, bus_be}, 32'd0);
        chk("rst_stall",    {31'h0, stall_mem}, 32'd0);
        chk("rst_wb_wd",    WB_wD, 32'd0);
        chk("rst_have_wb",  {31'h0, have_inst_WB}, 32'd0);
        chk("rst_misalign", {31'h0, misalign}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU op passes through in one cycle with no stall
        set_op(1'b1, 32'h1234, 32'h0, 1'b0, 2'b10, 1'b1, 3'd0, 32'h44, 32'h0, mk_inst(3'b000, 5'd5));
        run_op(0, 32'h0);
        chk("alu_stalls", op_stalls, 0);
        chk("alu_wd",     WB_wD, 32'h1234);
        chk("alu_wr",     {27'h0, WB_wR}, 32'd5);
        chk("alu_rf_we",  {31'h0, WB_rf_we}, 32'd1);
        chk("alu_have",   {31'h0, have_inst_WB}, 32'd1);

        // pc4 and ext write-back selects
        set_op(1'b1, 32'h9, 32'h0, 1'b0, 2'b10, 1'b1, 3'd2, 32'h104, 32'h0, mk_inst(3'b000, 5'd1));
        run_op(0, 32'h0);
        chk("pc4_wd", WB_wD, 32'h104);
        set_op(1'b1, 32'h9, 32'h0, 1'b0, 2'b10, 1'b1, 3'd3, 32'h0, 32'hFFFFFFF0, mk_inst(3'b000, 5'd2));
        run_op(0, 32'h0);
        chk("ext_wd", WB_wD, 32'hFFFFFFF0);

        // sb at 0x1002, ack one cycle late
        set_op(1'b1, 32'h1002, 32'hAABBCCDD, 1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, mk_inst(3'b000, 5'd0));
        run_op(1, 32'h0);
        bubble();
        chk("sb_be",     {28'h0, cap_be}, 32'h4);
        chk("sb_wdata",  cap_wdata, 32'hDDDDDDDD);
        chk("sb_addr",   cap_addr, 32'h1000);
        chk("sb_we",     {31'h0, cap_we}, 32'd1);
        chk("sb_stalls", op_stalls, 2);
        chk("sb_starts", op_starts, 1);
        chk("sb_rf_we",  {31'h0, WB_rf_we}, 32'd0);
        chk("sb_have",   {31'h0, have_inst_WB}, 32'd1);

        // lb / lbu at 0x2003
        set_op(1'b1, 32'h2003, 32'h0, 1'b0, 2'b00, 1'b1, 3'd1, 32'h0, 32'h0, mk_inst(3'b000, 5'd7));
        run_op(0, 32'h80FFFFFF);
        chk("lb_wd",     WB_wD, 32'hFFFFFF80);
        chk("lb_stalls", op_stalls, 1);
        chk("lb_be",     {28'h0, cap_be}, 32'hF);
        chk("lb_addr",   cap_addr, 32'h2000);
        set_op(1'b1, 32'h2003, 32'h0, 1'b0, 2'b00, 1'b1, 3'd1, 32'h0, 32'h0, mk_inst(3'b100, 5'd7));
        run_op(0, 32'h80FFFFFF);
        chk("lbu_wd",    WB_wD, 32'h00000080);

        // lh upper lane, ack after two wait cycles; earlier rdata is junk
        set_op(1'b1, 32'h5002, 32'h0, 1'b0, 2'b01, 1'b1, 3'd1, 32'h0, 32'h0, mk_inst(3'b001, 5'd9));
        run_op(2, 32'h80017777);
        chk("lh_wd",     WB_wD, 32'hFFFF8001);
        chk("lh_stalls", op_stalls, 3);
        chk("lh_rf_we",  {31'h0, WB_rf_we}, 32'd1);

        // sh upper lane
        set_op(1'b1, 32'h5002, 32'h1111BEEF, 1'b1, 2'b01, 1'b0, 3'd0, 32'h0, 32'h0, mk_inst(3'b001, 5'd0));
        run_op(0, 32'h0);
        chk("sh_be",    {28'h0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);

        // misaligned lh at 0x3001
        set_op(1'b1, 32'h3001, 32'h0, 1'b0, 2'b01, 1'b1, 3'd1, 32'h0, 32'h0, mk_inst(3'b001, 5'd3));
        run_op(0, 32'h0);
        bubble();
        chk("mis_starts",  op_starts, 0);
        chk("mis_stalls",  op_stalls, 0);
        chk("mis_flag",    {31'h0, misalign}, 32'd1);
        chk("mis_rf_we",   {31'h0, WB_rf_we}, 32'd0);
        chk("mis_have",    {31'h0, have_inst_WB}, 32'd1);
        @(posedge clk);
        #1;
        chk("mis_pulse_end", {31'h0, misalign}, 32'd0);

        // back-to-back lw (ack 0) then sw (ack 3)
        wb_base = wb_pulses;
        set_op(1'b1, 32'h4008, 32'h0, 1'b0, 2'b10, 1'b1, 3'd1, 32'h0, 32'h0, mk_inst(3'b010, 5'd10));
        run_op(0, 32'h12345678);
        chk("b2b_lw_wd",     WB_wD, 32'h12345678);
        chk("b2b_lw_starts", op_starts, 1);
        set_op(1'b1, 32'h400C, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0, 3'd0, 32'h0, 32'h0, mk_inst(3'b010, 5'd0));
        run_op(3, 32'h0);
        bubble();
        chk("b2b_sw_starts", op_starts, 1);
        chk("b2b_sw_stalls", op_stalls, 4);
        chk("b2b_sw_wdata",  cap_wdata, 32'hCAFEF00D);
        chk("b2b_sw_be",     {28'h0, cap_be}, 32'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("b2b_wb_pulses", wb_pulses - wb_base, 2);

        // reset while BUSY with ack withheld
        set_op(1'b1, 32'h6000, 32'h0, 1'b0, 2'b10, 1'b1, 3'd1, 32'h0, 32'h0, mk_inst(3'b010, 5'd11));
        @(posedge clk);
        #1;
        chk("busy_req", {31'h0, bus_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_req",   {31'h0, bus_req}, 32'd0);
        chk("mrst_stall", {31'h0, stall_mem}, 32'd0);
        chk("mrst_addr",  bus_addr, 32'd0);
        chk("mrst_have",  {31'h0, have_inst_WB}, 32'd0);
        chk("mrst_rf_we", {31'h0, WB_rf_we}, 32'd0);
        bubble();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus_ack = 1'b1;
        bus_rdata = 32'h55555555;
        #1;
        chk("late_ack_stall", {31'h0, stall_mem}, 32'd0);
        @(posedge clk);
        #1;
        chk("late_ack_req",  {31'h0, bus_req}, 32'd0);
        chk("late_ack_have", {31'h0, have_inst_WB}, 32'd0);
        bus_ack = 1'b0;
        set_op(1'b1, 32'h6000, 32'h0, 1'b0, 2'b10, 1'b1, 3'd1, 32'h0, 32'h0, mk_inst(3'b010, 5'd11));
        run_op(0, 32'h0BADF00D);
        bubble();
        chk("post_rst_wd",     WB_wD, 32'h0BADF00D);
        chk("post_rst_starts", op_starts, 1);
        chk("post_rst_wr",     {27'h0, WB_wR}, 32'd11);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
